// File: rtl/axi_lite_master_if.sv
// Command/response port plus the five AXI4-Lite channels of the single-outstanding master.
// Signal prefixes are written from the master's point of view.
interface axi_lite_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_wr;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic [31:0]           i_cmd_wdata;
  logic [3:0]            i_cmd_wstrb;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic                  o_rsp_wr;
  logic [1:0]            o_rsp_resp;
  logic [31:0]           o_rsp_data;
  logic                  o_awvalid;
  logic [ADDR_WIDTH-1:0] o_awaddr;
  logic                  i_awready;
  logic                  o_wvalid;
  logic                  i_wready;
  logic [31:0]           o_wdata;
  logic [3:0]            o_wstrb;
  logic                  i_bvalid;
  logic                  o_bready;
  logic [1:0]            i_bresp;
  logic                  o_arvalid;
  logic                  i_arready;
  logic [ADDR_WIDTH-1:0] o_araddr;
  logic                  i_rvalid;
  logic                  o_rready;
  logic [1:0]            i_rresp;
  logic [31:0]           i_rdata;

  modport master (
    input  i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_wdata, i_cmd_wstrb, i_rsp_ready,
    input  i_awready, i_wready, i_bvalid, i_bresp, i_arready, i_rvalid, i_rresp, i_rdata,
    output o_cmd_ready, o_rsp_valid, o_rsp_wr, o_rsp_resp, o_rsp_data,
    output o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready,
    output o_arvalid, o_araddr, o_rready
  );

  modport slave (
    output i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_wdata, i_cmd_wstrb, i_rsp_ready,
    output i_awready, i_wready, i_bvalid, i_bresp, i_arready, i_rvalid, i_rresp, i_rdata,
    input  o_cmd_ready, o_rsp_valid, o_rsp_wr, o_rsp_resp, o_rsp_data,
    input  o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready,
    input  o_arvalid, o_araddr, o_rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out, one response back.
// Every output is a register; the combinational process computes the next value of each.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32
) (
  input logic              i_axi_clk,
  input logic              i_axi_rst,
  axi_lite_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t                state, state_d;
  logic                  cmd_ready_d, rsp_valid_d, rsp_wr_d;
  logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic [31:0]           wdata_d, rsp_data_d;
  logic [3:0]            wstrb_d;
  logic [1:0]            rsp_resp_d;

  always_comb begin
    state_d     = state;
    rsp_valid_d = bus.o_rsp_valid;
    rsp_wr_d    = bus.o_rsp_wr;
    rsp_resp_d  = bus.o_rsp_resp;
    rsp_data_d  = bus.o_rsp_data;
    awvalid_d   = bus.o_awvalid;
    wvalid_d    = bus.o_wvalid;
    bready_d    = bus.o_bready;
    arvalid_d   = bus.o_arvalid;
    rready_d    = bus.o_rready;
    awaddr_d    = bus.o_awaddr;
    araddr_d    = bus.o_araddr;
    wdata_d     = bus.o_wdata;
    wstrb_d     = bus.o_wstrb;

    case (state)
      IDLE: begin
        if (bus.i_cmd_valid && bus.o_cmd_ready) begin
          if (bus.i_cmd_wr) begin
            awaddr_d  = bus.i_cmd_addr;
            wdata_d   = bus.i_cmd_wdata;
            wstrb_d   = bus.i_cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = bus.i_cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; the B phase starts once neither is still pending.
        if (bus.o_awvalid && bus.i_awready) awvalid_d = 1'b0;
        if (bus.o_wvalid && bus.i_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.i_bvalid && bus.o_bready) begin
          rsp_resp_d  = bus.i_bresp;
          rsp_wr_d    = 1'b1;
          rsp_data_d  = 32'h0;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (bus.o_arvalid && bus.i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.i_rvalid && bus.o_rready) begin
          rsp_resp_d  = bus.i_rresp;
          rsp_data_d  = bus.i_rdata;
          rsp_wr_d    = 1'b0;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_axi_clk) begin
    if (i_axi_rst) begin
      state           <= IDLE;
      bus.o_cmd_ready <= 1'b1;
      bus.o_rsp_valid <= 1'b0;
      bus.o_rsp_wr    <= 1'b0;
      bus.o_rsp_resp  <= 2'b00;
      bus.o_rsp_data  <= 32'h0;
      bus.o_awvalid   <= 1'b0;
      bus.o_wvalid    <= 1'b0;
      bus.o_bready    <= 1'b0;
      bus.o_arvalid   <= 1'b0;
      bus.o_rready    <= 1'b0;
      bus.o_awaddr    <= '0;
      bus.o_araddr    <= '0;
      bus.o_wdata     <= 32'h0;
      bus.o_wstrb     <= 4'h0;
    end else begin
      state           <= state_d;
      bus.o_cmd_ready <= cmd_ready_d;
      bus.o_rsp_valid <= rsp_valid_d;
      bus.o_rsp_wr    <= rsp_wr_d;
      bus.o_rsp_resp  <= rsp_resp_d;
      bus.o_rsp_data  <= rsp_data_d;
      bus.o_awvalid   <= awvalid_d;
      bus.o_wvalid    <= wvalid_d;
      bus.o_bready    <= bready_d;
      bus.o_arvalid   <= arvalid_d;
      bus.o_rready    <= rready_d;
      bus.o_awaddr    <= awaddr_d;
      bus.o_araddr    <= araddr_d;
      bus.o_wdata     <= wdata_d;
      bus.o_wstrb     <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a configurable-latency 8-word AXI-Lite slave, a protocol monitor,
// directed scenarios and a randomised read/write run checked against a reference memory.
module tb_axi_lite_master;

  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_master_if #(.ADDR_WIDTH(AW)) bus ();

  axi_lite_master #(.ADDR_WIDTH(AW)) dut (
    .i_axi_clk(clk),
    .i_axi_rst(rst),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;
  int viol;
  int cyc;

  // Slave latency knobs: a ready rises after that many cycles of its valid being high.
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] b_resp_val = 2'b00;

  logic [31:0] mem [8];
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        got_aw, got_w, b_pend, r_pend;
  logic [2:0]  s_aidx, r_idx;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;

  always_comb begin
    bus.i_awready = (aw_cnt >= aw_dly);
    bus.i_wready  = (w_cnt >= w_dly);
    bus.i_arready = (ar_cnt >= ar_dly);
    bus.i_bvalid  = b_pend && (b_cnt >= b_dly);
    bus.i_bresp   = b_resp_val;
    bus.i_rvalid  = r_pend && (r_cnt >= r_dly);
    bus.i_rdata   = mem[r_idx];
    bus.i_rresp   = 2'b00;
  end

  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      s_aidx <= '0; r_idx <= '0; s_wdata <= '0; s_wstrb <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
    end else begin
      if (bus.o_awvalid && bus.i_awready) begin
        aw_cnt <= 0; got_aw <= 1'b1; s_aidx <= bus.o_awaddr[4:2];
      end else if (bus.o_awvalid) aw_cnt <= aw_cnt + 1;
      if (bus.o_wvalid && bus.i_wready) begin
        w_cnt <= 0; got_w <= 1'b1; s_wdata <= bus.o_wdata; s_wstrb <= bus.o_wstrb;
      end else if (bus.o_wvalid) w_cnt <= w_cnt + 1;
      if (bus.o_arvalid && bus.i_arready) begin
        ar_cnt <= 0; r_pend <= 1'b1; r_idx <= bus.o_araddr[4:2]; r_cnt <= 0;
      end else if (bus.o_arvalid) ar_cnt <= ar_cnt + 1;
      if (got_aw && got_w) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_aidx][8*b +: 8] <= s_wdata[8*b +: 8];
        got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
      end else if (b_pend) begin
        if (bus.i_bvalid && bus.o_bready) b_pend <= 1'b0;
        else if (!bus.i_bvalid) b_cnt <= b_cnt + 1;
      end
      if (r_pend) begin
        if (bus.i_rvalid && bus.o_rready) r_pend <= 1'b0;
        else if (!bus.i_rvalid) r_cnt <= r_cnt + 1;
      end
    end
  end

  // Protocol monitor: payload stable and valid held until accepted, no concurrent AW/AR.
  logic        p_aw, p_w, p_ar;
  logic [31:0] p_awaddr, p_araddr, p_wdata;
  logic [3:0]  p_wstrb;
  int          cmd_cyc, aw_cyc, w_cyc, b_hs, bready_cyc, ar_hi;

  always_ff @(posedge clk) begin
    p_aw     <= !rst && bus.o_awvalid && !bus.i_awready;
    p_w      <= !rst && bus.o_wvalid && !bus.i_wready;
    p_ar     <= !rst && bus.o_arvalid && !bus.i_arready;
    p_awaddr <= bus.o_awaddr;
    p_araddr <= bus.o_araddr;
    p_wdata  <= bus.o_wdata;
    p_wstrb  <= bus.o_wstrb;
    if (!rst) begin
      if (p_aw)
        assert (bus.o_awvalid === 1'b1 && bus.o_awaddr === p_awaddr) else begin
          $error("FAIL aw_hold observed=%b/%h required=1/%h", bus.o_awvalid, bus.o_awaddr, p_awaddr);
          viol <= viol + 1;
        end
      if (p_w)
        assert (bus.o_wvalid === 1'b1 && bus.o_wdata === p_wdata && bus.o_wstrb === p_wstrb) else begin
          $error("FAIL w_hold observed=%b/%h/%h required=1/%h/%h", bus.o_wvalid, bus.o_wdata,
                 bus.o_wstrb, p_wdata, p_wstrb);
          viol <= viol + 1;
        end
      if (p_ar)
        assert (bus.o_arvalid === 1'b1 && bus.o_araddr === p_araddr) else begin
          $error("FAIL ar_hold observed=%b/%h required=1/%h", bus.o_arvalid, bus.o_araddr, p_araddr);
          viol <= viol + 1;
        end
      assert (!(bus.o_awvalid && bus.o_arvalid)) else begin
        $error("FAIL aw_ar_overlap observed=1 required=0");
        viol <= viol + 1;
      end
      if (bus.i_cmd_valid && bus.o_cmd_ready) cmd_cyc <= cyc;
      if (bus.o_awvalid && bus.i_awready)     aw_cyc <= cyc;
      if (bus.o_wvalid && bus.i_wready)       w_cyc <= cyc;
      if (bus.i_bvalid && bus.o_bready)       b_hs <= b_hs + 1;
      if (bus.o_bready)                       bready_cyc <= bready_cyc + 1;
      if (bus.o_arvalid)                      ar_hi <= ar_hi + 1;
    end
  end

  logic [31:0] exp_mem [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    int n = 0;
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_wr    = wr;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_wdata = data;
    bus.i_cmd_wstrb = strb;
    while (bus.o_cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 64'(n < 100), 64'd1);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    if (wr)
      for (int b = 0; b < 4; b++)
        if (strb[b]) exp_mem[addr[4:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic get_rsp(input int hold, output logic rwr, output logic [1:0] rresp,
                         output logic [31:0] rdata);
    int n = 0;
    bus.i_rsp_ready = 1'b0;
    while (bus.o_rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrive", 64'(n < 200), 64'd1);
    rwr   = bus.o_rsp_wr;
    rresp = bus.o_rsp_resp;
    rdata = bus.o_rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold_valid", 64'(bus.o_rsp_valid), 64'd1);
      chk("rsp_hold_resp", 64'(bus.o_rsp_resp), 64'(rresp));
      chk("rsp_hold_data", 64'(bus.o_rsp_data), 64'(rdata));
      chk("cmd_ready_busy", 64'(bus.o_cmd_ready), 64'd0);
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    chk("rsp_done_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("idle_cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
  endtask

  initial begin
    logic        rwr;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    int          b0, br0, a0, n;
    bit          wr;
    logic [2:0]  idx;
    logic [31:0] d;
    logic [3:0]  s;

    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_wr    = 1'b0;
    bus.i_cmd_addr  = '0;
    bus.i_cmd_wdata = '0;
    bus.i_cmd_wstrb = '0;
    bus.i_rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_valids", 64'({bus.o_cmd_ready, bus.o_awvalid, bus.o_wvalid, bus.o_bready,
                           bus.o_arvalid, bus.o_rready, bus.o_rsp_valid}), 64'b1000000);
    chk("rst_awaddr", 64'(bus.o_awaddr), 64'd0);
    chk("rst_araddr", 64'(bus.o_araddr), 64'd0);
    chk("rst_wdata_wstrb", 64'({bus.o_wdata, bus.o_wstrb}), 64'd0);
    chk("rst_rsp_fields", 64'({bus.o_rsp_wr, bus.o_rsp_resp, bus.o_rsp_data}), 64'd0);
    rst = 1'b0;

    // Write with all slave readies already high.
    b0 = b_hs; br0 = bready_cyc;
    issue(1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
    get_rsp(0, rwr, rresp, rdata);
    chk("wr1_rsp", 64'({rwr, rresp, rdata}), 64'({1'b1, 2'b00, 32'h0}));
    chk("wr1_aw_latency", 64'(aw_cyc - cmd_cyc), 64'd1);
    chk("wr1_w_latency", 64'(w_cyc - cmd_cyc), 64'd1);
    chk("wr1_bready_seen", 64'(bready_cyc > br0), 64'd1);
    chk("wr1_b_count", 64'(b_hs - b0), 64'd1);

    // Read back with AR stalled three cycles.
    ar_dly = 3; a0 = ar_hi;
    issue(1'b0, 32'h04, 32'h0, 4'h0);
    get_rsp(0, rwr, rresp, rdata);
    chk("rd1_rsp", 64'({rwr, rresp, rdata}), 64'({1'b0, 2'b00, 32'hDEADBEEF}));
    chk("rd1_arvalid_cycles", 64'(ar_hi - a0), 64'd4);
    ar_dly = 0;

    // Split write handshakes, AW late then W late.
    aw_dly = 4; b0 = b_hs;
    issue(1'b1, 32'h10, 32'hA5A50001, 4'hF);
    get_rsp(0, rwr, rresp, rdata);
    chk("split_aw_rsp", 64'({rwr, rresp}), 64'b100);
    chk("split_aw_aw_lat", 64'(aw_cyc - cmd_cyc), 64'd5);
    chk("split_aw_w_lat", 64'(w_cyc - cmd_cyc), 64'd1);
    chk("split_aw_b_count", 64'(b_hs - b0), 64'd1);
    aw_dly = 0; w_dly = 4; b0 = b_hs;
    issue(1'b1, 32'h14, 32'h5A5A0002, 4'hF);
    get_rsp(0, rwr, rresp, rdata);
    chk("split_w_rsp", 64'({rwr, rresp}), 64'b100);
    chk("split_w_aw_lat", 64'(aw_cyc - cmd_cyc), 64'd1);
    chk("split_w_w_lat", 64'(w_cyc - cmd_cyc), 64'd5);
    chk("split_w_b_count", 64'(b_hs - b0), 64'd1);
    w_dly = 0;

    // SLVERR with five cycles of response backpressure, partial strobes.
    b_resp_val = 2'b10;
    issue(1'b1, 32'h18, 32'hCAFEBEEF, 4'b0011);
    get_rsp(5, rwr, rresp, rdata);
    chk("slverr_rsp", 64'({rwr, rresp, rdata}), 64'({1'b1, 2'b10, 32'h0}));
    b_resp_val = 2'b00;
    issue(1'b0, 32'h18, 32'h0, 4'h0);
    get_rsp(0, rwr, rresp, rdata);
    chk("strobe_readback", 64'(rdata), 64'h0000BEEF);

    // Reset pulse while waiting in RD_DATA.
    r_dly = 10; n = 0;
    issue(1'b0, 32'h08, 32'h0, 4'h0);
    while (bus.o_rready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_rd_data", 64'(n < 50), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_mem[i] = 32'h0;
    chk("midrst_valids", 64'({bus.o_cmd_ready, bus.o_awvalid, bus.o_wvalid, bus.o_bready,
                              bus.o_arvalid, bus.o_rready, bus.o_rsp_valid}), 64'b1000000);
    chk("midrst_araddr", 64'(bus.o_araddr), 64'd0);
    r_dly = 0;
    issue(1'b1, 32'h0C, 32'h12345678, 4'hF);
    get_rsp(0, rwr, rresp, rdata);
    chk("postrst_wr_rsp", 64'({rwr, rresp, rdata}), 64'({1'b1, 2'b00, 32'h0}));
    issue(1'b0, 32'h0C, 32'h0, 4'h0);
    get_rsp(0, rwr, rresp, rdata);
    chk("postrst_rd_rsp", 64'({rwr, rresp, rdata}), 64'({1'b0, 2'b00, 32'h12345678}));

    // Randomised traffic with random slave and response-side delays.
    for (int k = 0; k < 200; k++) begin
      aw_dly = $urandom_range(0, 5); w_dly = $urandom_range(0, 5); ar_dly = $urandom_range(0, 5);
      b_dly  = $urandom_range(0, 5); r_dly = $urandom_range(0, 5);
      wr  = 1'($urandom_range(0, 1));
      idx = 3'($urandom_range(0, 7));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      if (wr) begin
        issue(1'b1, {27'h0, idx, 2'b00}, d, s);
        get_rsp($urandom_range(0, 2), rwr, rresp, rdata);
        chk("stress_wr", 64'({rwr, rresp, rdata}), 64'({1'b1, 2'b00, 32'h0}));
      end else begin
        issue(1'b0, {27'h0, idx, 2'b00}, 32'h0, 4'h0);
        get_rsp($urandom_range(0, 2), rwr, rresp, rdata);
        chk("stress_rd", 64'({rwr, rresp, rdata}), 64'({1'b0, 2'b00, exp_mem[idx]}));
      end
    end

    chk("protocol_violations", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
